// File: rtl/sram_arbiter.sv
// sram_arbiter: three-way arbiter (boot, cpu, video) onto one async SRAM.
// Ports:
//   clk, reset              : clock, sync active-high reset
//   boot_req/addr/wdata/ack : bootloader write channel (top priority)
//   cpu_req/we/addr/wdata   : cpu read/write channel
//   cpu_rdata/ack           : cpu read data and completion pulse
//   vid_req/addr            : video fetch channel (read-only)
//   vid_rdata/ack           : video byte and completion pulse
//   sram_a/dout/din/oe      : SRAM address, pad data out/in, pad enable
//   sram_nwe/noe/nce        : SRAM strobes, active low
module sram_arbiter #(
  parameter int unsigned WR_PULSE = 2,
  parameter logic [2:0]  VID_BASE = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_req,
  input  logic [15:0] boot_addr,
  input  logic [7:0]  boot_wdata,
  output logic        boot_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic [18:0] sram_a,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_oe,
  output logic        sram_nwe,
  output logic        sram_noe,
  output logic        sram_nce
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    O_NONE,
    O_BOOT,
    O_CPU,
    O_VID
  } owner_t;

  localparam logic [2:0] CNT_LAST = 3'(WR_PULSE - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        rr_cpu_q, rr_cpu_d;
  logic [18:0] sram_a_q, sram_a_d;
  logic [7:0]  sram_dout_q, sram_dout_d;
  logic        sram_oe_q, sram_oe_d;
  logic        sram_nwe_q, sram_nwe_d;
  logic        sram_noe_q, sram_noe_d;
  logic        boot_ack_q, boot_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vid_rdata_q, vid_rdata_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rr_cpu_d    = rr_cpu_q;
    sram_a_d    = sram_a_q;
    sram_dout_d = sram_dout_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          state_d     = S_SETUP;
          owner_d     = O_BOOT;
          we_d        = 1'b1;
          sram_a_d    = {3'b000, boot_addr};
          sram_dout_d = boot_wdata;
        end else if (cpu_req && (!vid_req || rr_cpu_q)) begin
          state_d     = S_SETUP;
          owner_d     = O_CPU;
          we_d        = cpu_we;
          sram_a_d    = {3'b000, cpu_addr};
          sram_dout_d = cpu_wdata;
          rr_cpu_d    = 1'b0;
        end else if (vid_req) begin
          state_d     = S_SETUP;
          owner_d     = O_VID;
          we_d        = 1'b0;
          sram_a_d    = {3'b000, VID_BASE, vid_addr};
          sram_dout_d = 8'h00;
          rr_cpu_d    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 3'd0;
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          // sram_din is sampled on the edge closing the strobe window
          if (!we_q && owner_q == O_CPU) cpu_rdata_d = sram_din;
          if (!we_q && owner_q == O_VID) vid_rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they leave a flop
    sram_oe_d  = we_d && (state_d != S_IDLE);
    sram_nwe_d = !(we_d && state_d == S_ACCESS);
    sram_noe_d = !(!we_d &&
                   (state_d == S_SETUP || state_d == S_ACCESS));
    boot_ack_d = (state_d == S_DONE) && (owner_d == O_BOOT);
    cpu_ack_d  = (state_d == S_DONE) && (owner_d == O_CPU);
    vid_ack_d  = (state_d == S_DONE) && (owner_d == O_VID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= O_NONE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      rr_cpu_q    <= 1'b1;
      sram_a_q    <= 19'd0;
      sram_dout_q <= 8'h00;
      sram_oe_q   <= 1'b0;
      sram_nwe_q  <= 1'b1;
      sram_noe_q  <= 1'b1;
      boot_ack_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      vid_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      rr_cpu_q    <= rr_cpu_d;
      sram_a_q    <= sram_a_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      sram_nwe_q  <= sram_nwe_d;
      sram_noe_q  <= sram_noe_d;
      boot_ack_q  <= boot_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign boot_ack  = boot_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign sram_a    = sram_a_q;
  assign sram_dout = sram_dout_q;
  assign sram_oe   = sram_oe_q;
  assign sram_nwe  = sram_nwe_q;
  assign sram_noe  = sram_noe_q;
  assign sram_nce  = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a byte SRAM model.
// Extra instances cover WR_PULSE = 1 and 7.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        boot_req, cpu_req, cpu_we, vid_req;
  logic [15:0] boot_addr, cpu_addr;
  logic [7:0]  boot_wdata, cpu_wdata;
  logic [12:0] vid_addr;
  logic        boot_ack, cpu_ack, vid_ack;
  logic [7:0]  cpu_rdata, vid_rdata;
  logic [18:0] sram_a;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_oe, sram_nwe, sram_noe, sram_nce;

  bit [7:0] mem [0:524287];
  assign sram_din = mem[sram_a];
  always @(posedge clk)
    if (!sram_nwe) mem[sram_a] <= sram_dout;

  sram_arbiter u_dut (
    .clk(clk), .reset(reset),
    .boot_req(boot_req), .boot_addr(boot_addr),
    .boot_wdata(boot_wdata), .boot_ack(boot_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_oe(sram_oe), .sram_nwe(sram_nwe), .sram_noe(sram_noe),
    .sram_nce(sram_nce)
  );

  logic        req1, req7, ack1, ack7;
  logic [7:0]  c1_rd, v1_rd, c7_rd, v7_rd, d1, d7;
  logic [18:0] a1, a7;
  logic        oe1, oe7, nwe1, nwe7, noe1, noe7, nce1, nce7;

  sram_arbiter #(.WR_PULSE(1)) u_p1 (
    .clk(clk), .reset(reset),
    .boot_req(req1), .boot_addr(boot_addr),
    .boot_wdata(boot_wdata), .boot_ack(ack1),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000),
    .cpu_wdata(8'h00), .cpu_rdata(c1_rd), .cpu_ack(),
    .vid_req(1'b0), .vid_addr(13'h0000),
    .vid_rdata(v1_rd), .vid_ack(),
    .sram_a(a1), .sram_dout(d1), .sram_din(8'h00),
    .sram_oe(oe1), .sram_nwe(nwe1), .sram_noe(noe1),
    .sram_nce(nce1)
  );

  sram_arbiter #(.WR_PULSE(7)) u_p7 (
    .clk(clk), .reset(reset),
    .boot_req(req7), .boot_addr(boot_addr),
    .boot_wdata(boot_wdata), .boot_ack(ack7),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000),
    .cpu_wdata(8'h00), .cpu_rdata(c7_rd), .cpu_ack(),
    .vid_req(1'b0), .vid_addr(13'h0000),
    .vid_rdata(v7_rd), .vid_ack(),
    .sram_a(a7), .sram_dout(d7), .sram_din(8'h00),
    .sram_oe(oe7), .sram_nwe(nwe7), .sram_noe(noe7),
    .sram_nce(nce7)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk)
    chk("nwe_noe_excl",
        {29'd0, ~sram_nwe & ~sram_noe, ~nwe1 & ~noe1, ~nwe7 & ~noe7},
        32'd0);

  // One access from an idle arbiter; inputs are scrambled after grant.
  task automatic access(input int who,
                        output int lat, output int nwe_n,
                        output int noe_n, output int oe_bad,
                        output logic [7:0] rd,
                        output logic [7:0] dout_w,
                        output logic [18:0] a_ack);
    lat = 0; nwe_n = 0; noe_n = 0; oe_bad = 0;
    rd = 0; dout_w = 0; a_ack = 0;
    @(posedge clk); #1;
    case (who)
      0: boot_req = 1'b1;
      1: cpu_req  = 1'b1;
      default: vid_req = 1'b1;
    endcase
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        boot_addr  = ~boot_addr;
        boot_wdata = ~boot_wdata;
        cpu_addr   = ~cpu_addr;
        cpu_wdata  = ~cpu_wdata;
        cpu_we     = ~cpu_we;
        vid_addr   = ~vid_addr;
      end
      if (!sram_nwe) begin
        nwe_n++;
        dout_w = sram_dout;
        if (!sram_oe) oe_bad++;
      end
      if (!sram_noe) begin
        noe_n++;
        if (sram_oe) oe_bad++;
      end
      if ((who == 0 && boot_ack) || (who == 1 && cpu_ack) ||
          (who == 2 && vid_ack)) begin
        lat   = i;
        rd    = (who == 2) ? vid_rdata : cpu_rdata;
        a_ack = sram_a;
        break;
      end
    end
    boot_req = 1'b0;
    cpu_req  = 1'b0;
    vid_req  = 1'b0;
  endtask

  int          lat, nwe_n, noe_n, oe_bad, cnt;
  logic [7:0]  rd, dw;
  logic [18:0] aa;
  logic [2:0]  exp_ack;
  int          lat1, lat7, n1, n7;

  initial begin
    reset = 1'b1;
    boot_req = 0; cpu_req = 0; vid_req = 0; cpu_we = 0;
    boot_addr = 0; cpu_addr = 0; boot_wdata = 0; cpu_wdata = 0;
    vid_addr = 0; req1 = 0; req7 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nwe", {31'd0, sram_nwe}, 32'd1);
    chk("rst_noe", {31'd0, sram_noe}, 32'd1);
    chk("rst_oe", {31'd0, sram_oe}, 32'd0);
    chk("rst_a", {13'd0, sram_a}, 32'd0);
    chk("rst_dout", {24'd0, sram_dout}, 32'd0);
    chk("rst_acks", {29'd0, boot_ack, cpu_ack, vid_ack}, 32'd0);
    chk("rst_rdata", {16'd0, cpu_rdata, vid_rdata}, 32'd0);
    chk("rst_nce", {31'd0, sram_nce}, 32'd0);
    reset = 1'b0;

    boot_addr = 16'h1234; boot_wdata = 8'hA5;
    access(0, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("boot_lat", lat, 4);
    chk("boot_nwe_cycles", nwe_n, 2);
    chk("boot_noe_cycles", noe_n, 0);
    chk("boot_dout", {24'd0, dw}, 32'h A5);
    chk("boot_oe", oe_bad, 0);
    chk("boot_addr", {13'd0, aa}, 32'h01234);
    chk("boot_mem", {24'd0, mem[19'h01234]}, 32'hA5);
    @(posedge clk); #1;
    chk("boot_ack_pulse", {31'd0, boot_ack}, 32'd0);

    boot_addr = 16'h00F0; boot_wdata = 8'h5A;
    access(0, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    boot_addr = 16'h8010; boot_wdata = 8'hC3;
    access(0, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("preset_mem", {16'd0, mem[19'h000F0], mem[19'h08010]},
        32'h5AC3);

    cpu_we = 1'b0; cpu_addr = 16'h00F0;
    access(1, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("cpu_rd_lat", lat, 4);
    chk("cpu_rd_noe_cycles", noe_n, 3);
    chk("cpu_rd_nwe_cycles", nwe_n, 0);
    chk("cpu_rd_oe", oe_bad, 0);
    chk("cpu_rd_data", {24'd0, rd}, 32'h5A);
    chk("cpu_rd_addr", {13'd0, aa}, 32'h000F0);
    repeat (3) @(posedge clk);
    #1;
    chk("cpu_rd_hold", {24'd0, cpu_rdata}, 32'h5A);

    vid_addr = 13'h0010;
    access(2, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("vid_lat", lat, 4);
    chk("vid_noe_cycles", noe_n, 3);
    chk("vid_addr", {13'd0, aa}, 32'h08010);
    chk("vid_data", {24'd0, rd}, 32'hC3);

    cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h77;
    access(1, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("cpu_wr_lat", lat, 4);
    chk("cpu_wr_nwe_cycles", nwe_n, 2);
    chk("cpu_wr_dout", {24'd0, dw}, 32'h77);
    chk("cpu_wr_mem", {24'd0, mem[19'h00200]}, 32'h77);
    chk("cpu_wr_rdata_kept", {24'd0, cpu_rdata}, 32'h5A);

    // Reset while a cpu write is strobing
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h99;
    cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre_nwe", {31'd0, sram_nwe}, 32'd0);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_nwe", {31'd0, sram_nwe}, 32'd1);
    chk("abort_oe", {31'd0, sram_oe}, 32'd0);
    chk("abort_ack", {31'd0, cpu_ack}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) cnt++;
    end
    chk("abort_no_ack", cnt, 0);
    cpu_we = 1'b0; cpu_addr = 16'h00F0;
    access(1, lat, nwe_n, noe_n, oe_bad, rd, dw, aa);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_data", {24'd0, rd}, 32'h5A);

    // Contention from reset release, boot joins mid-stream
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h00F0; vid_addr = 13'h0010;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c == 17) begin
        boot_req = 1'b1; boot_addr = 16'h0400; boot_wdata = 8'h3C;
      end
      exp_ack = 3'b000;
      if (c == 4 || c == 14 || c == 29) exp_ack = 3'b010;
      if (c == 9 || c == 19 || c == 34) exp_ack = 3'b001;
      if (c == 24) exp_ack = 3'b100;
      chk($sformatf("contend_acks_c%0d", c),
          {29'd0, boot_ack, cpu_ack, vid_ack}, {29'd0, exp_ack});
      if (boot_ack) boot_req = 1'b0;
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    chk("contend_rdata", {16'd0, cpu_rdata, vid_rdata}, 32'h5AC3);
    chk("contend_boot_mem", {24'd0, mem[19'h00400]}, 32'h3C);

    // WR_PULSE sweep on the extra instances
    boot_addr = 16'h0055; boot_wdata = 8'h11;
    @(posedge clk); #1;
    req1 = 1'b1; req7 = 1'b1;
    lat1 = 0; lat7 = 0; n1 = 0; n7 = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (!nwe1) n1++;
      if (!nwe7) n7++;
      if (ack1 && lat1 == 0) begin
        lat1 = i; req1 = 1'b0;
      end
      if (ack7 && lat7 == 0) begin
        lat7 = i; req7 = 1'b0;
      end
    end
    req1 = 1'b0; req7 = 1'b0;
    chk("p1_lat", lat1, 3);
    chk("p7_lat", lat7, 9);
    chk("p1_nwe_cycles", n1, 1);
    chk("p7_nwe_cycles", n7, 7);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WR_PULSE, default 2: number of clk cycles the ACCESS state lasts (legal range 1-7).
REQ-002 Parameter VID_BASE, default 3'b100: address bits [15:13] prepended to video addresses (#8000 window).
REQ-003 clk  in  1  single clock for all logic; every port is sampled and driven on its rising edge.
REQ-004 reset  in  1  synchronous, active-high; takes effect on the first rising edge of clk at which it is high.
REQ-005 boot_req  in  1  bootloader write request; held high until boot_ack is seen.
REQ-006 boot_addr  in  16  bootloader write address.
REQ-007 boot_wdata  in  8  bootloader write data.
REQ-008 boot_ack  out  1  single-cycle pulse marking completion of the boot write.
REQ-009 cpu_req  in  1  CPU access request; held high until cpu_ack is seen.
REQ-010 cpu_we  in  1  CPU access type: 1 = write, 0 = read.
REQ-011 cpu_addr  in  16  CPU address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_rdata  out  8  CPU read data; valid in the cpu_ack cycle and held until the next CPU read completes.
REQ-014 cpu_ack  out  1  single-cycle pulse marking completion of the CPU access.
REQ-015 vid_req  in  1  video fetch request, read-only; held high until vid_ack is seen.
REQ-016 vid_addr  in  13  video RAM offset.
REQ-017 vid_rdata  out  8  fetched video byte; valid in the vid_ack cycle and held until the next fetch completes.
REQ-018 vid_ack  out  1  single-cycle pulse marking completion of the video fetch.
REQ-019 sram_a  out  19  SRAM address.
REQ-020 sram_dout  out  8  write data driven to the SRAM data pads.
REQ-021 sram_din  in  8  read data returned from the SRAM data pads.
REQ-022 sram_oe  out  1  pad output enable; 1 = pads drive the SRAM data bus.
REQ-023 sram_nwe  out  1  SRAM write strobe, active low.
REQ-024 sram_noe  out  1  SRAM output enable, active low.
REQ-025 sram_nce  out  1  SRAM chip enable, active low; held constant at 0.

Function
REQ-026 The state machine SHALL have four states, IDLE, SETUP, ACCESS and DONE, and SHALL move IDLE->SETUP on grant, SETUP->ACCESS after 1 cycle, ACCESS->DONE after WR_PULSE cycles, and DONE->IDLE after 1 cycle.
REQ-027 Arbitration SHALL occur only in IDLE.
    - boot_req has absolute priority.
    - Between cpu_req and vid_req, priority SHALL be round-robin: the requester granted last (cpu or vid) loses a tie.
REQ-028 At grant, the requester's address, type and write data SHALL be captured into internal registers; later changes on the inputs SHALL NOT affect the access in flight.
REQ-029 sram_a SHALL be formed as follows:
    - boot and cpu: {3'b000, addr}.
    - video: {3'b000, VID_BASE, vid_addr}.
    - sram_a SHALL be stable from SETUP through DONE.
REQ-030 Write access:
    - sram_oe = 1 and sram_dout = captured data in SETUP, ACCESS and DONE.
    - sram_nwe = 0 only in ACCESS.
    - sram_noe = 1 throughout.
REQ-031 Read access:
    - sram_oe = 0 throughout.
    - sram_noe = 0 in SETUP and ACCESS.
    - sram_din SHALL be registered on the last ACCESS cycle into cpu_rdata or vid_rdata.
REQ-032 The ack SHALL be a 1-cycle pulse in DONE, to the granted requester only; grant-to-ack latency = 2 + WR_PULSE cycles (default 4), counted from the IDLE cycle in which the grant is made.
REQ-033 A requester whose req is still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-034 Back-to-back accesses SHALL have a minimum period of 3 + WR_PULSE cycles (IDLE included).
REQ-035 Simultaneous boot_req, cpu_req and vid_req SHALL be served in the order boot first, then the round-robin winner, then the remaining requester; no requester SHALL wait more than 2 full access periods once boot_req is low.
REQ-036 sram_nwe and sram_noe SHALL be registered outputs, free of glitches.
REQ-037 sram_nwe and sram_noe SHALL never be low in the same cycle.

Reset
REQ-038 While reset is high, on the next clk edge:
    - state = IDLE.
    - sram_nwe = 1, sram_noe = 1, sram_oe = 0, sram_a = 0, sram_dout = 0.
    - all acks = 0, cpu_rdata = 0, vid_rdata = 0.
    - round-robin pointer = cpu-favoured.
REQ-039 Reset asserted mid-access SHALL abort the access without issuing an ack; requesters re-issue after reset.

Verification
REQ-040 Boot write: boot_req=1, boot_addr=#1234, boot_wdata=#A5 -> sram_a=#01234; sram_nwe low for exactly 2 cycles with sram_dout=#A5 and sram_oe=1; boot_ack 4 cycles after grant.
REQ-041 CPU read: SRAM model holds #5A at #00F0; cpu_req=1, cpu_we=0, cpu_addr=#00F0 -> sram_noe low for 3 cycles, cpu_rdata=#5A with cpu_ack; sram_nwe never low.
REQ-042 Video fetch: vid_addr=#0010 -> sram_a=#08010; vid_rdata equals the model byte in the vid_ack cycle.
REQ-043 Contention: cpu_req and vid_req both held high from reset release -> grants alternate cpu, vid, cpu, ...; ack spacing = 5 cycles; adding boot_req mid-stream -> boot is served at the next IDLE.
REQ-044 Reset during ACCESS of a CPU write -> sram_nwe=1 and sram_oe=0 on the next edge; no cpu_ack; state returns to IDLE.
REQ-045 Sweep WR_PULSE values 1 and 7 -> latency = 3 and 9 cycles; sram_nwe and sram_noe never low together (assertion).
